// File: rtl/evm_ballot_controller.sv
// Election session sequencer for a 4-candidate electronic voting machine.
// It issues one ballot at a time, turns a single new button press into one vote,
// keeps four saturating vote counters and latches the external comparator's
// winner code when voting closes.
//
// Handshake note: there is no valid/ready pairing on this block. Officer inputs
// are level-sampled commands that only act in their own state, and every event
// output (vote_ack, invalid_press, ballot_expired) is a registered pulse lasting
// exactly one cycle. These pulses appear on the cycle after the event.
module evm_ballot_controller #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_election,
  input  logic             ballot_en,
  input  logic             close_election,
  input  logic [3:0]       cand_btn,
  input  logic [2:0]       winner_in,
  output logic [CNT_W-1:0] votecount1,
  output logic [CNT_W-1:0] votecount2,
  output logic [CNT_W-1:0] votecount3,
  output logic [CNT_W-1:0] votecount4,
  output logic [2:0]       winner_out,
  output logic             result_valid,
  output logic             ballot_active,
  output logic             vote_ack,
  output logic             invalid_press,
  output logic             ballot_expired,
  output logic [2:0]       state_o
);

  // The timer counts down from TIMEOUT_CYC-1 to 0, so it never needs to hold TIMEOUT_CYC.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_BALLOT = 3'd2,
    S_TALLY  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [3:0]       btn_q;
  logic [3:0]       rise;
  logic             rise_one_hot;
  logic             rise_multi;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt [4];

  // A button counts only on the cycle it goes from released to pressed.
  // A button that was already held when the ballot opened therefore never votes.
  assign rise         = cand_btn & ~btn_q;
  assign rise_one_hot = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
  assign rise_multi   = (rise != 4'd0) && !rise_one_hot;

  assign votecount1    = cnt[0];
  assign votecount2    = cnt[1];
  assign votecount3    = cnt[2];
  assign votecount4    = cnt[3];
  assign result_valid  = (state == S_DONE);
  assign ballot_active = (state == S_BALLOT);
  assign state_o       = state;

  // Registers the previous button level used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 4'd0;
    else     btn_q <= cand_btn;
  end

  // Session FSM: owns the counters, the ballot timer, the latched result and the event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      timer          <= '0;
      winner_out     <= 3'b000;
      vote_ack       <= 1'b0;
      invalid_press  <= 1'b0;
      ballot_expired <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      vote_ack       <= 1'b0;
      invalid_press  <= 1'b0;
      ballot_expired <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_election) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            state <= S_READY;
          end
        end
        S_READY: begin
          // Closing wins over issuing a ballot in the same cycle.
          if (close_election) begin
            state <= S_TALLY;
          end else if (ballot_en) begin
            timer <= TMR_LOAD;
            state <= S_BALLOT;
          end
        end
        S_BALLOT: begin
          if (close_election) begin
            // The open ballot is abandoned without recording anything.
            ballot_expired <= 1'b1;
            state          <= S_TALLY;
          end else if (rise_one_hot) begin
            // Only the counter whose button rose can change; it stops at full scale.
            for (int i = 0; i < 4; i++) begin
              if (rise[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
            vote_ack <= 1'b1;
            state    <= S_READY;
          end else if (rise_multi) begin
            // Ambiguous press: reject it and let the voter try again. The timer keeps running
            // but is held at zero so the expiry is taken on a following cycle.
            invalid_press <= 1'b1;
            if (timer != '0) timer <= timer - TMR_W'(1);
          end else if (timer == '0) begin
            ballot_expired <= 1'b1;
            state          <= S_READY;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_TALLY: begin
          // Counters have been stable for a full cycle, so the comparator output has settled.
          winner_out <= winner_in;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (start_election) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            winner_out <= 3'b000;
            state      <= S_READY;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Directed bench for evm_ballot_controller with a short ballot timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_evm_ballot_controller;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_election;
  logic             ballot_en;
  logic             close_election;
  logic [3:0]       cand_btn;
  logic [2:0]       winner_in;
  logic [CNT_W-1:0] votecount1, votecount2, votecount3, votecount4;
  logic [2:0]       winner_out;
  logic             result_valid, ballot_active;
  logic             vote_ack, invalid_press, ballot_expired;
  logic [2:0]       state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int ack_base;
  logic ack;

  // clock / reset block
  always #5 clk = ~clk;

  evm_ballot_controller #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .start_election(start_election), .ballot_en(ballot_en), .close_election(close_election),
    .cand_btn(cand_btn), .winner_in(winner_in),
    .votecount1(votecount1), .votecount2(votecount2), .votecount3(votecount3), .votecount4(votecount4),
    .winner_out(winner_out), .result_valid(result_valid), .ballot_active(ballot_active),
    .vote_ack(vote_ack), .invalid_press(invalid_press), .ballot_expired(ballot_expired),
    .state_o(state_o)
  );

  // Counts vote_ack pulses; each pulse lasts one cycle, so it is seen at exactly one edge.
  always @(posedge clk) if (vote_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one complete ballot with a single clean press of candidate idx (0-based)
  task automatic cast_vote(input int idx, output logic ack_seen);
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    cand_btn  = 4'(1 << idx);
    tick();
    ack_seen  = vote_ack;
    cand_btn  = 4'd0;
    tick();
  endtask

  task automatic check_counts(input string tag, input int c1, input int c2, input int c3, input int c4);
    check({tag, "_c1"}, 32'(votecount1), 32'(c1));
    check({tag, "_c2"}, 32'(votecount2), 32'(c2));
    check({tag, "_c3"}, 32'(votecount3), 32'(c3));
    check({tag, "_c4"}, 32'(votecount4), 32'(c4));
  endtask

  initial begin
    rst = 1'b1; start_election = 1'b0; ballot_en = 1'b0; close_election = 1'b0;
    cand_btn = 4'd0; winner_in = 3'b000;
    tick(); tick();
    // reset has priority over start_election
    start_election = 1'b1;
    tick();
    check("rst_state", 32'(state_o), 32'd0);
    check_counts("rst", 0, 0, 0, 0);
    check("rst_winner", 32'(winner_out), 32'd0);
    check("rst_flags", {26'd0, result_valid, ballot_active, vote_ack, invalid_press, ballot_expired, 1'b0}, 32'd0);
    start_election = 1'b0;
    rst = 1'b0;
    tick();

    // 1: three votes for candidate 2
    start_election = 1'b1;
    tick();
    start_election = 1'b0;
    check("t1_ready", 32'(state_o), 32'd1);
    ack_base = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      cast_vote(1, ack);
      check("t1_ack", 32'(ack), 32'd1);
    end
    check_counts("t1", 0, 3, 0, 0);
    check("t1_ack_total", 32'(ack_cnt - ack_base), 32'd3);

    // 2: two buttons rise together, then candidate 3 alone
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("t2_ballot", 32'(state_o), 32'd2);
    check("t2_active", 32'(ballot_active), 32'd1);
    cand_btn = 4'b0101;
    tick();
    check("t2_invalid", 32'(invalid_press), 32'd1);
    check("t2_stay", 32'(state_o), 32'd2);
    check("t2_noack", 32'(vote_ack), 32'd0);
    cand_btn = 4'b0000;
    tick();
    check("t2_inv_pulse", 32'(invalid_press), 32'd0);
    ack_base = ack_cnt;
    cand_btn = 4'b0100;
    tick();
    check("t2_ack", 32'(vote_ack), 32'd1);
    cand_btn = 4'b0000;
    tick();
    check_counts("t2", 0, 3, 1, 0);
    check("t2_ack_total", 32'(ack_cnt - ack_base), 32'd1);

    // 3: no press, ballot expires 4 cycles after entering BALLOT
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_wait%0d", i), 32'(ballot_expired), 32'd0);
      if (i < 4) tick();
      else begin
        check("t3_still_ballot", 32'(state_o), 32'd2);
        tick();
      end
    end
    check("t3_expired", 32'(ballot_expired), 32'd1);
    check("t3_ready", 32'(state_o), 32'd1);
    check_counts("t3", 0, 3, 1, 0);

    // 4: button held before the ballot never counts; release and press counts once
    cand_btn = 4'b0001;
    tick();
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    tick();
    check("t4_held_noack", 32'(vote_ack), 32'd0);
    check("t4_held_c1", 32'(votecount1), 32'd0);
    cand_btn = 4'b0000;
    tick();
    cand_btn = 4'b0001;
    tick();
    check("t4_ack", 32'(vote_ack), 32'd1);
    cand_btn = 4'b0000;
    tick();
    check_counts("t4", 1, 3, 1, 0);

    // close while a ballot is open aborts it, even with a press in the same cycle
    winner_in = 3'b111;
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    close_election = 1'b1;
    cand_btn = 4'b0001;
    tick();
    close_election = 1'b0;
    cand_btn = 4'b0000;
    check("abort_expired", 32'(ballot_expired), 32'd1);
    check("abort_noack", 32'(vote_ack), 32'd0);
    check("abort_tally", 32'(state_o), 32'd3);
    tick();
    check("abort_done", 32'(state_o), 32'd4);
    check("abort_winner", 32'(winner_out), 32'd7);
    check_counts("abort", 1, 3, 1, 0);
    start_election = 1'b1;
    tick();
    start_election = 1'b0;
    check("restart_ready", 32'(state_o), 32'd1);
    check("restart_winner", 32'(winner_out), 32'd0);
    check("restart_valid", 32'(result_valid), 32'd0);
    check_counts("restart", 0, 0, 0, 0);

    // 5: votes 2/5/1/0, close, latch comparator code
    for (int i = 0; i < 2; i++) cast_vote(0, ack);
    for (int i = 0; i < 5; i++) cast_vote(1, ack);
    cast_vote(2, ack);
    check_counts("t5", 2, 5, 1, 0);
    winner_in = 3'b010;
    close_election = 1'b1;
    tick();
    close_election = 1'b0;
    check("t5_tally", 32'(state_o), 32'd3);
    check("t5_valid_early", 32'(result_valid), 32'd0);
    tick();
    check("t5_valid", 32'(result_valid), 32'd1);
    check("t5_winner", 32'(winner_out), 32'd2);
    check("t5_done", 32'(state_o), 32'd4);
    winner_in = 3'b100;
    ballot_en = 1'b1;
    cand_btn = 4'b1000;
    tick(); tick();
    check("t5_hold_state", 32'(state_o), 32'd4);
    check("t5_hold_winner", 32'(winner_out), 32'd2);
    check("t5_hold_noack", 32'(vote_ack), 32'd0);
    check_counts("t5_hold", 2, 5, 1, 0);
    ballot_en = 1'b0;
    cand_btn = 4'b0000;
    tick();

    // 6: saturation at 255, then reset mid-ballot
    start_election = 1'b1;
    tick();
    start_election = 1'b0;
    for (int i = 0; i < 255; i++) cast_vote(3, ack);
    check("t6_full", 32'(votecount4), 32'd255);
    cast_vote(3, ack);
    check("t6_sat_ack", 32'(ack), 32'd1);
    check_counts("t6_sat", 0, 0, 0, 255);
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("t6_ballot", 32'(state_o), 32'd2);
    cand_btn = 4'b0001;
    rst = 1'b1;
    tick();
    check("t6_rst_state", 32'(state_o), 32'd0);
    check("t6_rst_noack", 32'(vote_ack), 32'd0);
    check("t6_rst_active", 32'(ballot_active), 32'd0);
    check_counts("t6_rst", 0, 0, 0, 0);
    rst = 1'b0;
    cand_btn = 4'b0000;
    tick();
    // IDLE ignores everything except start_election
    ballot_en = 1'b1;
    close_election = 1'b1;
    tick();
    check("t6_idle_ignore", 32'(state_o), 32'd0);
    ballot_en = 1'b0;
    close_election = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
